// File: rtl/board_pkg.sv
// Shared constants for the fading board recorder: cell marks, reject codes, FSM states.
package board_pkg;

    // Cell contents / move marks
    localparam logic [1:0] MARK_EMPTY = 2'b00;
    localparam logic [1:0] MARK_O     = 2'b01;
    localparam logic [1:0] MARK_X     = 2'b10;
    localparam logic [1:0] MARK_BAD   = 2'b11;

    // Reject codes reported on rej_code
    localparam logic [1:0] REJ_NONE     = 2'b00;
    localparam logic [1:0] REJ_BAD      = 2'b01;
    localparam logic [1:0] REJ_OCCUPIED = 2'b10;
    localparam logic [1:0] REJ_TURN     = 2'b11;

    // Recorder FSM states
    typedef logic [1:0] state_t;
    localparam state_t ST_EMPTY  = 2'd0;
    localparam state_t ST_PLAY   = 2'd1;
    localparam state_t ST_FROZEN = 2'd2;

    // Player whose turn follows the given one
    function automatic logic [1:0] other_mark(input logic [1:0] m);
        return (m == MARK_O) ? MARK_X : MARK_O;
    endfunction

endpackage

// File: rtl/move_fifo.sv
// Circular FIFO of cell positions for one player's live marks.
// Ports:
//   clk, rst (sync active-low), flush (sync clear)
//   push/din  : append a position; ignored when full unless popped in the same cycle
//   pop       : drop the oldest position; ignored when empty
//   head      : oldest live position (valid when count != 0)
//   count     : number of live entries
module move_fifo #(
    parameter  int unsigned DEPTH = 3,
    parameter  int unsigned WIDTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointer advance with wrap at DEPTH (DEPTH need not be a power of two)
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Guards keep the FIFO from underflowing or overflowing
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= bump(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= bump(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fading_board_recorder.sv
// Fading tic-tac-toe mark recorder: SIDE x SIDE board, each player keeps at most
// DEPTH live marks; a player's extra mark erases that player's oldest mark on the same edge.
// Ports:
//   clk, rst (sync active-low), clear (sync new game), freeze (game over, blocks moves)
//   move_valid/move_ready/move_mark/move_pos : move handshake (move_ready combinational)
//   board                  : registered cells, cell i at [2i+1:2i]
//   cnt_o/cnt_x            : live marks per player
//   next_fade_o/x, nf_valid_o/x : oldest live mark, flagged when it goes on the next move
//   fade_valid/fade_pos    : pulse + held position of the last erased cell
//   rej_valid/rej_code     : pulse + held code of the last rejected move
module fading_board_recorder
    import board_pkg::*;
#(
    parameter  int unsigned SIDE         = 3,
    parameter  int unsigned DEPTH        = 3,
    parameter  int unsigned ENFORCE_TURN = 1,
    localparam int unsigned CELLS        = SIDE * SIDE,
    localparam int unsigned POS_W        = $clog2(CELLS),
    localparam int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               freeze,
    input  logic               move_valid,
    output logic               move_ready,
    input  logic [1:0]         move_mark,
    input  logic [POS_W-1:0]   move_pos,
    output logic [2*CELLS-1:0] board,
    output logic [CNT_W-1:0]   cnt_o,
    output logic [CNT_W-1:0]   cnt_x,
    output logic [POS_W-1:0]   next_fade_o,
    output logic [POS_W-1:0]   next_fade_x,
    output logic               nf_valid_o,
    output logic               nf_valid_x,
    output logic               fade_valid,
    output logic [POS_W-1:0]   fade_pos,
    output logic               rej_valid,
    output logic [1:0]         rej_code
);

    logic [1:0]       cells     [CELLS];
    logic [1:0]       cells_nxt [CELLS];
    state_t           state;
    state_t           state_nxt;
    logic [1:0]       turn;
    logic [1:0]       turn_nxt;
    logic             fade_valid_nxt;
    logic [POS_W-1:0] fade_pos_nxt;
    logic             rej_valid_nxt;
    logic [1:0]       rej_code_nxt;

    logic [1:0]       cur_cell;
    logic             pos_bad;
    logic             occupied;
    logic             turn_bad;
    logic             fire;
    logic             accept;
    logic             reject;
    logic             push_o;
    logic             push_x;
    logic             pop_o;
    logic             pop_x;
    logic             fade_now;
    logic [POS_W-1:0] fade_head;

    assign move_ready = ~clear & (state != ST_FROZEN);
    assign fire       = move_valid & move_ready;

    // Current content of the addressed cell; out-of-range positions read as empty
    always_comb begin
        cur_cell = MARK_EMPTY;
        for (int unsigned i = 0; i < CELLS; i++) begin
            if (move_pos == POS_W'(i)) begin
                cur_cell = cells[i];
            end
        end
    end

    // Legality checks, evaluated against the board as it stands before the edge
    assign pos_bad  = (32'(move_pos) >= CELLS) || (move_mark == MARK_EMPTY) || (move_mark == MARK_BAD);
    assign occupied = (cur_cell != MARK_EMPTY);
    assign turn_bad = (ENFORCE_TURN != 0) && (move_mark != turn);
    assign accept   = fire && !pos_bad && !occupied && !turn_bad;
    assign reject   = fire && !accept;

    // A full player's FIFO pops its head on the same edge as the new push
    assign nf_valid_o = (cnt_o == CNT_W'(DEPTH));
    assign nf_valid_x = (cnt_x == CNT_W'(DEPTH));
    assign push_o     = accept && (move_mark == MARK_O);
    assign push_x     = accept && (move_mark == MARK_X);
    assign pop_o      = push_o && nf_valid_o;
    assign pop_x      = push_x && nf_valid_x;
    assign fade_now   = pop_o || pop_x;
    assign fade_head  = pop_o ? next_fade_o : next_fade_x;

    move_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (POS_W)
    ) u_fifo_o (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (push_o),
        .pop   (pop_o),
        .din   (move_pos),
        .head  (next_fade_o),
        .count (cnt_o)
    );

    move_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (POS_W)
    ) u_fifo_x (
        .clk   (clk),
        .rst   (rst),
        .flush (clear),
        .push  (push_x),
        .pop   (pop_x),
        .din   (move_pos),
        .head  (next_fade_x),
        .count (cnt_x)
    );

    // FSM next state plus next values of every registered output
    always_comb begin
        state_nxt      = state;
        turn_nxt       = turn;
        fade_valid_nxt = 1'b0;
        fade_pos_nxt   = fade_pos;
        rej_valid_nxt  = 1'b0;
        rej_code_nxt   = rej_code;
        cells_nxt      = cells;

        if (reject) begin
            rej_valid_nxt = 1'b1;
            if (pos_bad) begin
                rej_code_nxt = REJ_BAD;
            end else if (occupied) begin
                rej_code_nxt = REJ_OCCUPIED;
            end else begin
                rej_code_nxt = REJ_TURN;
            end
        end

        if (accept) begin
            turn_nxt = other_mark(turn);
        end

        if (fade_now) begin
            fade_valid_nxt = 1'b1;
            fade_pos_nxt   = fade_head;
        end

        // New mark and faded head never share a cell: one is empty, the other occupied
        for (int unsigned i = 0; i < CELLS; i++) begin
            if (accept && (move_pos == POS_W'(i))) begin
                cells_nxt[i] = move_mark;
            end else if (fade_now && (fade_head == POS_W'(i))) begin
                cells_nxt[i] = MARK_EMPTY;
            end
        end

        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    state_nxt = ST_PLAY;
                end
            end
            ST_PLAY: begin
                state_nxt = ST_PLAY;
            end
            ST_FROZEN: begin
                if (!freeze) begin
                    state_nxt = ((cnt_o == '0) && (cnt_x == '0)) ? ST_EMPTY : ST_PLAY;
                end
            end
            default: begin
                state_nxt = ST_EMPTY;
            end
        endcase

        if (freeze) begin
            state_nxt = ST_FROZEN;
        end
    end

    // State and output registers; clear behaves exactly like reset
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            state      <= ST_EMPTY;
            turn       <= MARK_O;
            fade_valid <= 1'b0;
            fade_pos   <= '0;
            rej_valid  <= 1'b0;
            rej_code   <= REJ_NONE;
            for (int unsigned i = 0; i < CELLS; i++) begin
                cells[i] <= MARK_EMPTY;
            end
        end else begin
            state      <= state_nxt;
            turn       <= turn_nxt;
            fade_valid <= fade_valid_nxt;
            fade_pos   <= fade_pos_nxt;
            rej_valid  <= rej_valid_nxt;
            rej_code   <= rej_code_nxt;
            cells      <= cells_nxt;
        end
    end

    // Flatten the cell array onto the board bus
    for (genvar g = 0; g < CELLS; g++) begin : g_board
        assign board[2*g +: 2] = cells[g];
    end

endmodule

// File: tb/tb_fading_board_recorder.sv
// Self-checking bench: two recorder instances (3x3/depth 3/turns enforced and
// 4x4/depth 4/free turns) checked cycle by cycle against a reference model.
module tb_fading_board_recorder;
    import board_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance A: SIDE=3, DEPTH=3, ENFORCE_TURN=1
    logic        a_clear, a_freeze, a_valid, a_ready;
    logic [1:0]  a_mark;
    logic [3:0]  a_pos;
    logic [17:0] a_board;
    logic [1:0]  a_cnt_o, a_cnt_x;
    logic [3:0]  a_nf_o, a_nf_x, a_fade_p;
    logic        a_nfv_o, a_nfv_x, a_fade_v, a_rej_v;
    logic [1:0]  a_rej_c;

    // Instance B: SIDE=4, DEPTH=4, ENFORCE_TURN=0
    logic        b_clear, b_freeze, b_valid, b_ready;
    logic [1:0]  b_mark;
    logic [3:0]  b_pos;
    logic [31:0] b_board;
    logic [2:0]  b_cnt_o, b_cnt_x;
    logic [3:0]  b_nf_o, b_nf_x, b_fade_p;
    logic        b_nfv_o, b_nfv_x, b_fade_v, b_rej_v;
    logic [1:0]  b_rej_c;

    fading_board_recorder #(.SIDE(3), .DEPTH(3), .ENFORCE_TURN(1)) dut_a (
        .clk(clk), .rst(rst), .clear(a_clear), .freeze(a_freeze),
        .move_valid(a_valid), .move_ready(a_ready), .move_mark(a_mark), .move_pos(a_pos),
        .board(a_board), .cnt_o(a_cnt_o), .cnt_x(a_cnt_x),
        .next_fade_o(a_nf_o), .next_fade_x(a_nf_x), .nf_valid_o(a_nfv_o), .nf_valid_x(a_nfv_x),
        .fade_valid(a_fade_v), .fade_pos(a_fade_p), .rej_valid(a_rej_v), .rej_code(a_rej_c)
    );

    fading_board_recorder #(.SIDE(4), .DEPTH(4), .ENFORCE_TURN(0)) dut_b (
        .clk(clk), .rst(rst), .clear(b_clear), .freeze(b_freeze),
        .move_valid(b_valid), .move_ready(b_ready), .move_mark(b_mark), .move_pos(b_pos),
        .board(b_board), .cnt_o(b_cnt_o), .cnt_x(b_cnt_x),
        .next_fade_o(b_nf_o), .next_fade_x(b_nf_x), .nf_valid_o(b_nfv_o), .nf_valid_x(b_nfv_x),
        .fade_valid(b_fade_v), .fade_pos(b_fade_p), .rej_valid(b_rej_v), .rej_code(b_rej_c)
    );

    // Observable snapshot; next_fade is only meaningful while its valid flag is set
    typedef struct packed {
        logic [31:0] board;
        logic [3:0]  cnt_o;
        logic [3:0]  cnt_x;
        logic        nfv_o;
        logic [3:0]  nf_o;
        logic        nfv_x;
        logic [3:0]  nf_x;
        logic        fade_v;
        logic [3:0]  fade_p;
        logic        rej_v;
        logic [1:0]  rej_c;
    } obs_t;

    int total = 0;
    int bad   = 0;
    obs_t sb[$];

    // Reference model of the instance under test
    int         m_cells;
    int         m_depth;
    bit         m_enf;
    logic [1:0] m_b [16];
    int         m_qo[$];
    int         m_qx[$];
    logic [1:0] m_turn;
    state_t     m_state;
    logic       m_fv;
    int         m_fp;
    logic       m_rv;
    logic [1:0] m_rc;

    function automatic void model_reset();
        for (int i = 0; i < 16; i++) m_b[i] = MARK_EMPTY;
        m_qo.delete();
        m_qx.delete();
        m_turn  = MARK_O;
        m_state = ST_EMPTY;
        m_fv = 1'b0; m_fp = 0; m_rv = 1'b0; m_rc = 2'b00;
    endfunction

    function automatic void model_select(input bit sel);
        m_cells = sel ? 16 : 9;
        m_depth = sel ? 4 : 3;
        m_enf   = !sel;
        model_reset();
    endfunction

    function automatic obs_t model_snapshot();
        obs_t s = '0;
        for (int i = 0; i < m_cells; i++) s.board[2*i +: 2] = m_b[i];
        s.cnt_o  = 4'(m_qo.size());
        s.cnt_x  = 4'(m_qx.size());
        s.nfv_o  = (m_qo.size() == m_depth);
        s.nf_o   = s.nfv_o ? 4'(m_qo[0]) : 4'd0;
        s.nfv_x  = (m_qx.size() == m_depth);
        s.nf_x   = s.nfv_x ? 4'(m_qx[0]) : 4'd0;
        s.fade_v = m_fv;
        s.fade_p = 4'(m_fp);
        s.rej_v  = m_rv;
        s.rej_c  = m_rc;
        return s;
    endfunction

    function automatic void model_cycle(input bit v, input logic [1:0] mk, input int pos,
                                        input bit clr, input bit frz);
        bit ready = !clr && (m_state != ST_FROZEN);
        bit acc = 1'b0;
        int h;
        if (clr) begin
            model_reset();
        end else begin
            m_fv = 1'b0;
            m_rv = 1'b0;
            if (v && ready) begin
                if (pos >= m_cells || mk == MARK_EMPTY || mk == MARK_BAD) begin
                    m_rv = 1'b1; m_rc = 2'b01;
                end else if (m_b[pos] != MARK_EMPTY) begin
                    m_rv = 1'b1; m_rc = 2'b10;
                end else if (m_enf && mk != m_turn) begin
                    m_rv = 1'b1; m_rc = 2'b11;
                end else begin
                    acc = 1'b1;
                    m_b[pos] = mk;
                    if (mk == MARK_O) begin
                        if (m_qo.size() == m_depth) begin
                            h = m_qo.pop_front(); m_b[h] = MARK_EMPTY; m_fv = 1'b1; m_fp = h;
                        end
                        m_qo.push_back(pos);
                    end else begin
                        if (m_qx.size() == m_depth) begin
                            h = m_qx.pop_front(); m_b[h] = MARK_EMPTY; m_fv = 1'b1; m_fp = h;
                        end
                        m_qx.push_back(pos);
                    end
                    m_turn = (m_turn == MARK_O) ? MARK_X : MARK_O;
                end
            end
            if (frz) m_state = ST_FROZEN;
            else if (m_state == ST_FROZEN)
                m_state = (m_qo.size() + m_qx.size() == 0) ? ST_EMPTY : ST_PLAY;
            else if (m_state == ST_EMPTY && acc) m_state = ST_PLAY;
        end
        sb.push_back(model_snapshot());
    endfunction

    function automatic obs_t observe(input bit sel);
        obs_t o = '0;
        if (!sel) begin
            o.board = 32'(a_board); o.cnt_o = 4'(a_cnt_o); o.cnt_x = 4'(a_cnt_x);
            o.nfv_o = a_nfv_o; o.nf_o = a_nfv_o ? a_nf_o : 4'd0;
            o.nfv_x = a_nfv_x; o.nf_x = a_nfv_x ? a_nf_x : 4'd0;
            o.fade_v = a_fade_v; o.fade_p = a_fade_p; o.rej_v = a_rej_v; o.rej_c = a_rej_c;
        end else begin
            o.board = b_board; o.cnt_o = 4'(b_cnt_o); o.cnt_x = 4'(b_cnt_x);
            o.nfv_o = b_nfv_o; o.nf_o = b_nfv_o ? b_nf_o : 4'd0;
            o.nfv_x = b_nfv_x; o.nf_x = b_nfv_x ? b_nf_x : 4'd0;
            o.fade_v = b_fade_v; o.fade_p = b_fade_p; o.rej_v = b_rej_v; o.rej_c = b_rej_c;
        end
        return o;
    endfunction

    // Drive one clock of stimulus on the selected instance and queue the model's expectation
    task automatic cycle(input bit sel, input bit v, input logic [1:0] mk, input int pos,
                         input bit clr, input bit frz);
        if (!sel) begin
            a_valid = v; a_mark = mk; a_pos = 4'(pos); a_clear = clr; a_freeze = frz;
        end else begin
            b_valid = v; b_mark = mk; b_pos = 4'(pos); b_clear = clr; b_freeze = frz;
        end
        model_cycle(v, mk, pos, clr, frz);
        @(negedge clk);
        a_valid = 1'b0; b_valid = 1'b0; a_clear = 1'b0; b_clear = 1'b0;
    endtask

    task automatic test_reset();
        obs_t exp, got;
        rst = 1'b0;
        a_clear = 0; a_freeze = 0; a_valid = 0; a_mark = 0; a_pos = 0;
        b_clear = 0; b_freeze = 0; b_valid = 0; b_mark = 0; b_pos = 0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        model_select(1'b0);
        sb.push_back(model_snapshot());
        exp = sb.pop_front(); got = observe(1'b0); total++;
        if (got !== exp) begin bad++; $display("FAIL reset_state got=%h exp=%h", got, exp); end
        total++;
        if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", a_ready); end
    endtask

    task automatic test_basic();
        logic [1:0] mk [3] = '{MARK_O, MARK_X, MARK_O};
        int         ps [3] = '{4, 0, 8};
        obs_t exp, got;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, mk[i], ps[i], 1'b0, 1'b0);
            exp = sb.pop_front(); got = observe(1'b0); total++;
            if (got !== exp) begin bad++; $display("FAIL basic[%0d] got=%h exp=%h", i, got, exp); end
        end
        total++;
        if ({a_board[9:8], a_board[1:0], a_board[17:16], a_cnt_o, a_cnt_x, a_fade_v, a_rej_v} !== 12'b01_10_01_10_01_0_0) begin
            bad++; $display("FAIL basic_board got=%h cnt_o=%0d cnt_x=%0d exp cells 4=1 0=2 8=1 cnt 2/1", a_board, a_cnt_o, a_cnt_x);
        end
    endtask

    task automatic test_fade();
        logic [1:0] mk [8] = '{MARK_O, MARK_X, MARK_O, MARK_X, MARK_O, MARK_X, MARK_O, MARK_X};
        int         ps [8] = '{0, 3, 1, 4, 2, 5, 6, 3};
        obs_t exp, got;
        cycle(1'b0, 1'b0, MARK_EMPTY, 0, 1'b1, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, mk[i], ps[i], 1'b0, 1'b0);
            exp = sb.pop_front(); got = observe(1'b0); total++;
            if (got !== exp) begin bad++; $display("FAIL fade[%0d] got=%h exp=%h", i, got, exp); end
            if (i == 4) begin
                total++;
                if ({a_nfv_o, a_nf_o} !== 5'b1_0000) begin
                    bad++; $display("FAIL fade_nf_o got=%b/%0d exp=1/0", a_nfv_o, a_nf_o);
                end
            end
            if (i == 6) begin
                total++;
                if ({a_board[1:0], a_board[13:12], a_fade_v, a_fade_p, a_cnt_o} !== 11'b00_01_1_0000_11) begin
                    bad++; $display("FAIL fade_o6 got cell0=%b cell6=%b fv=%b fp=%0d cnt_o=%0d exp 00 01 1 0 3",
                                    a_board[1:0], a_board[13:12], a_fade_v, a_fade_p, a_cnt_o);
                end
            end
        end
        total++;
        if ({a_rej_v, a_rej_c} !== 3'b1_10) begin
            bad++; $display("FAIL fade_own_head got=%b/%b exp=1/10", a_rej_v, a_rej_c);
        end
    endtask

    task automatic test_reject();
        logic [1:0] mk [6] = '{MARK_X, MARK_O, MARK_BAD, MARK_O, MARK_X, MARK_O};
        int         ps [6] = '{0, 9, 1, 0, 1, 1};
        logic [2:0] want [6] = '{3'b1_11, 3'b1_01, 3'b1_01, 3'b0_01, 3'b0_01, 3'b1_10};
        obs_t exp, got;
        cycle(1'b0, 1'b0, MARK_EMPTY, 0, 1'b1, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b1, mk[i], ps[i], 1'b0, 1'b0);
            exp = sb.pop_front(); got = observe(1'b0); total++;
            if (got !== exp) begin bad++; $display("FAIL reject[%0d] got=%h exp=%h", i, got, exp); end
            total++;
            if ({a_rej_v, a_rej_c} !== want[i]) begin
                bad++; $display("FAIL reject_code[%0d] got=%b exp=%b", i, {a_rej_v, a_rej_c}, want[i]);
            end
        end
        cycle(1'b0, 1'b0, MARK_EMPTY, 0, 1'b0, 1'b0);
        exp = sb.pop_front(); got = observe(1'b0); total++;
        if (got !== exp) begin bad++; $display("FAIL reject_idle got=%h exp=%h", got, exp); end
    endtask

    task automatic test_freeze();
        obs_t exp, got;
        cycle(1'b0, 1'b0, MARK_EMPTY, 0, 1'b0, 1'b1);
        void'(sb.pop_front());
        total++;
        if (a_ready !== 1'b0) begin bad++; $display("FAIL freeze_ready got=%b exp=0", a_ready); end
        cycle(1'b0, 1'b1, MARK_O, 2, 1'b0, 1'b1);
        exp = sb.pop_front(); got = observe(1'b0); total++;
        if (got !== exp) begin bad++; $display("FAIL freeze_blocked got=%h exp=%h", got, exp); end
        cycle(1'b0, 1'b0, MARK_EMPTY, 0, 1'b0, 1'b0);
        void'(sb.pop_front());
        total++;
        if (dut_a.state !== ST_PLAY || a_ready !== 1'b1) begin
            bad++; $display("FAIL freeze_release got state=%0d ready=%b exp state=%0d ready=1", dut_a.state, a_ready, ST_PLAY);
        end
        cycle(1'b0, 1'b1, MARK_O, 2, 1'b0, 1'b0);
        exp = sb.pop_front(); got = observe(1'b0); total++;
        if (got !== exp) begin bad++; $display("FAIL freeze_resume got=%h exp=%h", got, exp); end
    endtask

    task automatic test_clear();
        obs_t exp, got;
        cycle(1'b0, 1'b1, MARK_X, 5, 1'b1, 1'b0);
        exp = sb.pop_front(); got = observe(1'b0); total++;
        if (got !== exp || a_board !== 18'd0) begin bad++; $display("FAIL clear_drop got=%h exp=%h", got, exp); end
        cycle(1'b0, 1'b1, MARK_O, 4, 1'b0, 1'b0);
        exp = sb.pop_front(); got = observe(1'b0); total++;
        if (got !== exp || a_board[9:8] !== MARK_O) begin bad++; $display("FAIL clear_next got=%h exp=%h", got, exp); end
    endtask

    task automatic test_random();
        obs_t exp, got;
        logic [1:0] mk;
        int p;
        model_select(1'b1);
        cycle(1'b1, 1'b0, MARK_EMPTY, 0, 1'b1, 1'b0);
        void'(sb.pop_front());
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, MARK_O, i, 1'b0, 1'b0);
            exp = sb.pop_front(); got = observe(1'b1); total++;
            if (got !== exp) begin bad++; $display("FAIL free_o[%0d] got=%h exp=%h", i, got, exp); end
        end
        total++;
        if ({b_board[1:0], b_cnt_o, b_cnt_x, b_fade_v, b_fade_p} !== 13'b00_100_000_1_0000) begin
            bad++; $display("FAIL free_fade got cell0=%b cnt_o=%0d cnt_x=%0d fv=%b fp=%0d exp 00 4 0 1 0",
                            b_board[1:0], b_cnt_o, b_cnt_x, b_fade_v, b_fade_p);
        end
        for (int n = 0; n < 10; n++) begin
            mk = ($urandom_range(0, 1) == 0) ? MARK_O : MARK_X;
            p  = $urandom_range(0, 15);
            for (int k = 0; k < 16 && m_b[p] != MARK_EMPTY; k++) p = (p + 1) % 16;
            cycle(1'b1, 1'b1, mk, p, 1'b0, 1'b0);
            exp = sb.pop_front(); got = observe(1'b1); total++;
            if (got !== exp) begin bad++; $display("FAIL random[%0d] got=%h exp=%h", n, got, exp); end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fade();
        test_reject();
        test_freeze();
        test_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
